// File: rtl/fcmp_vec_collect.sv
// fcmp_vec_collect
//   Sits behind the ctrl-less two-stage FP compare unit. It gathers NUM_THREAD
//   scalar compare results, lane 0 first, into one vector writeback beat. It
//   also merges the per-lane fflags, counting active lanes only. The
//   per-instruction ctrl tag bypasses the compare unit through a small FIFO
//   and is re-attached to the vector when that vector is emitted.
//
//   Ports
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     ctrl_*_i / ctrl_ready_o
//                           tag push at issue time; ready means the FIFO is not full
//     elem_valid_i / elem_ready_o / elem_result_i / elem_fflags_i
//                           scalar results from the compare unit
//     out_valid_o / out_ready_i / out_result_o / out_fflags_o
//                           vector writeback beat, lane i at [i*XLEN +: XLEN]
//     out_regindex_o / out_warpid_o / out_vecmask_o / out_wvd_o / out_wxd_o
//                           tag at the FIFO head, zero when the FIFO is empty
`ifndef DEPTH_WARP
`define DEPTH_WARP 2
`endif

module fcmp_vec_collect #(
    parameter int NUM_THREAD = 4,
    parameter int XLEN       = 32,
    parameter int CTRL_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ctrl_valid_i,
    output logic                       ctrl_ready_o,
    input  logic [4:0]                 ctrl_regindex_i,
    input  logic [`DEPTH_WARP-1:0]     ctrl_warpid_i,
    input  logic [NUM_THREAD-1:0]      ctrl_vecmask_i,
    input  logic                       ctrl_wvd_i,
    input  logic                       ctrl_wxd_i,
    input  logic                       elem_valid_i,
    output logic                       elem_ready_o,
    input  logic [XLEN-1:0]            elem_result_i,
    input  logic [4:0]                 elem_fflags_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_THREAD*XLEN-1:0] out_result_o,
    output logic [4:0]                 out_fflags_o,
    output logic [4:0]                 out_regindex_o,
    output logic [`DEPTH_WARP-1:0]     out_warpid_o,
    output logic [NUM_THREAD-1:0]      out_vecmask_o,
    output logic                       out_wvd_o,
    output logic                       out_wxd_o
);

    localparam int PTR_W = $clog2(CTRL_DEPTH);
    localparam int CNT_W = $clog2(NUM_THREAD);
    localparam int TAG_W = 5 + `DEPTH_WARP + NUM_THREAD + 2;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_THREAD - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(CTRL_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_THREAD*XLEN-1:0] buf_q, buf_d;
    logic [4:0]                acc_q, acc_d;
    logic [TAG_W-1:0]          tag_mem_q [CTRL_DEPTH];
    logic [TAG_W-1:0]          tag_mem_d [CTRL_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]            count_q, count_d;

    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      push;
    logic                      fire;
    logic [TAG_W-1:0]          tag_in;
    logic [TAG_W-1:0]          head_tag;
    logic [NUM_THREAD-1:0]     head_mask;
    logic                      lane_en;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign push       = ctrl_valid_i && !fifo_full;
    assign fire       = (state_q == DONE) && out_ready_i;
    assign tag_in     = {ctrl_regindex_i, ctrl_warpid_i, ctrl_vecmask_i, ctrl_wvd_i, ctrl_wxd_i};
    assign head_tag   = tag_mem_q[rd_ptr_q];
    // The mask lives just above the wvd/wxd bits of the packed tag.
    assign head_mask  = head_tag[NUM_THREAD+1:2];
    assign lane_en    = head_mask[cnt_q];

    assign ctrl_ready_o = !fifo_full;
    assign elem_ready_o = (state_q == COLLECT);
    assign out_valid_o  = (state_q == DONE);
    // The buffer holds partial lanes while collecting; only expose it once complete.
    assign out_result_o = (state_q == DONE) ? buf_q : '0;
    assign out_fflags_o = (state_q == DONE) ? acc_q : '0;
    assign {out_regindex_o, out_warpid_o, out_vecmask_o, out_wvd_o, out_wxd_o} =
        fifo_empty ? '0 : head_tag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        acc_d     = acc_q;
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push) begin
            tag_mem_d[wr_ptr_q] = tag_in;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                // A freshly pushed tag is only seen here through the registered count.
                if (!fifo_empty) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (elem_valid_i) begin
                    // Masked-off lanes still consume a beat but contribute nothing.
                    buf_d[int'(cnt_q)*XLEN +: XLEN] = lane_en ? elem_result_i : '0;
                    acc_d = acc_q | (lane_en ? elem_fflags_i : 5'd0);
                    if (cnt_q == LAST_LANE) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (fire) begin
                    buf_d   = '0;
                    acc_d   = '0;
                    state_d = (count_d != '0) ? COLLECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            acc_q     <= '0;
            tag_mem_q <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            acc_q     <= acc_d;
            tag_mem_q <= tag_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
